// File: rtl/sid_pkg.sv
// Shared constants, the per-voice register layout and address-map helpers for the SID register bank.
package sid_pkg;

  localparam int unsigned VOICE_REGS  = 7;

  localparam int unsigned OFS_FREQ_LO = 0;
  localparam int unsigned OFS_FREQ_HI = 1;
  localparam int unsigned OFS_PW_LO   = 2;
  localparam int unsigned OFS_PW_HI   = 3;
  localparam int unsigned OFS_CONTROL = 4;
  localparam int unsigned OFS_ATT_DEC = 5;
  localparam int unsigned OFS_SUS_REL = 6;

  localparam int unsigned FOFS_FC_LO    = 0;
  localparam int unsigned FOFS_FC_HI    = 1;
  localparam int unsigned FOFS_RES_FILT = 2;
  localparam int unsigned FOFS_MODE_VOL = 3;
  localparam int unsigned FOFS_POT_X    = 4;
  localparam int unsigned FOFS_POT_Y    = 5;
  localparam int unsigned FOFS_OSC_MON  = 6;
  localparam int unsigned FOFS_ENV_MON  = 7;

  typedef struct packed {
    logic [7:0] freq_hi;
    logic [7:0] freq_lo;
    logic [3:0] pw_hi;
    logic [7:0] pw_lo;
    logic [7:0] control;
    logic [7:0] att_dec;
    logic [7:0] sus_rel;
  } voice_regs_t;

  // First filter register address; voices occupy everything below it.
  function automatic int unsigned filt_base(input int unsigned nvoices);
    return VOICE_REGS * nvoices;
  endfunction

endpackage

// File: rtl/sid_regbank_if.sv
// CPU-side register bus of the SID register bank.
interface sid_regbank_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              cs;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_in;
  logic [7:0]        data_out;

  modport master (output cs, we, addr, data_in, input data_out);
  modport slave  (input cs, we, addr, data_in, output data_out);
endinterface

// File: rtl/sid_bus_latch.sv
// Data-bus latch of the SID: holds the last bus value and clears it after DECAY_TICKS idle ticks.
module sid_bus_latch #(
  parameter int unsigned DECAY_TICKS = 8192
) (
  input  logic       clk32,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_data,
  output logic [7:0] bus_latch
);
  localparam int unsigned CNT_W = (DECAY_TICKS > 0) ? $clog2(DECAY_TICKS + 1) : 1;

  logic [CNT_W-1:0] r_decay_cnt;
  logic [7:0]       r_bus_latch;

  // A bus transfer always wins over a decay tick in the same cycle.
  always_ff @(posedge clk32) begin
    if (reset) begin
      r_decay_cnt <= '0;
      r_bus_latch <= '0;
    end else if (load) begin
      r_decay_cnt <= CNT_W'(DECAY_TICKS);
      r_bus_latch <= load_data;
    end else if (tick && (r_decay_cnt != '0)) begin
      r_decay_cnt <= r_decay_cnt - CNT_W'(1);
      if (r_decay_cnt == CNT_W'(1)) begin
        r_bus_latch <= '0;
      end
    end
  end

  assign bus_latch = r_bus_latch;

endmodule

// File: rtl/sid_regbank.sv
// Register bank and CPU bus front-end for the SID core: voice/filter registers,
// 1 MHz clock enable and the decaying data-bus latch.
module sid_regbank
  import sid_pkg::*;
#(
  parameter int unsigned NVOICES     = 3,
  parameter int unsigned CLK_DIV     = 32,
  parameter int unsigned DECAY_TICKS = 8192,
  parameter int unsigned ADDR_W      = 5
) (
  input  logic                   clk32,
  input  logic                   reset,
  sid_regbank_if.slave           bus,
  input  logic [7:0]             pot_x,
  input  logic [7:0]             pot_y,
  input  logic [7:0]             osc_mon,
  input  logic [7:0]             env_mon,
  output logic                   ce_1m,
  output logic [NVOICES*16-1:0]  freq,
  output logic [NVOICES*12-1:0]  pw,
  output logic [NVOICES*8-1:0]   control,
  output logic [NVOICES*8-1:0]   att_dec,
  output logic [NVOICES*8-1:0]   sus_rel,
  output logic [NVOICES-1:0]     ctrl_wr,
  output logic [7:0]             fc_lo,
  output logic [7:0]             fc_hi,
  output logic [7:0]             res_filt,
  output logic [7:0]             mode_vol
);
  localparam int unsigned F     = filt_base(NVOICES);
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic              w_wr;
  logic              w_rd;
  logic [ADDR_W-1:0] w_addr_raw;
  logic [31:0]       w_addr;
  logic [31:0]       w_frel;
  logic              w_rd_hit;
  logic [7:0]        w_rd_val;
  logic              w_load;
  logic [7:0]        w_load_data;
  logic [7:0]        w_bus_latch;
  logic [NVOICES-1:0] w_ctrl_hit;

  logic [DIV_W-1:0]   r_div;
  logic               r_ce_1m;
  logic [7:0]         r_data_out;
  logic [NVOICES-1:0] r_ctrl_wr;
  logic [7:0]         r_fc_lo;
  logic [7:0]         r_fc_hi;
  logic [7:0]         r_res_filt;
  logic [7:0]         r_mode_vol;

  assign w_wr       = bus.cs & bus.we;
  assign w_rd       = bus.cs & ~bus.we;
  assign w_addr_raw = bus.addr;
  assign w_addr     = 32'(w_addr_raw);
  // Addresses below F wrap to large values and never match a filter/read slot.
  assign w_frel     = w_addr - 32'(F);

  for (genvar v = 0; v < NVOICES; v++) begin : g_voice
    localparam int unsigned BASE = VOICE_REGS * v;
    logic [31:0] w_rel;
    voice_regs_t r_voice;

    assign w_rel         = w_addr - 32'(BASE);
    assign w_ctrl_hit[v] = w_wr & (w_rel == 32'(OFS_CONTROL));

    always_ff @(posedge clk32) begin
      if (reset) begin
        r_voice <= '0;
      end else if (w_wr) begin
        case (w_rel)
          32'(OFS_FREQ_LO): r_voice.freq_lo <= bus.data_in;
          32'(OFS_FREQ_HI): r_voice.freq_hi <= bus.data_in;
          32'(OFS_PW_LO):   r_voice.pw_lo   <= bus.data_in;
          32'(OFS_PW_HI):   r_voice.pw_hi   <= bus.data_in[3:0];
          32'(OFS_CONTROL): r_voice.control <= bus.data_in;
          32'(OFS_ATT_DEC): r_voice.att_dec <= bus.data_in;
          32'(OFS_SUS_REL): r_voice.sus_rel <= bus.data_in;
          default: ;
        endcase
      end
    end

    assign freq[16*v +: 16]  = {r_voice.freq_hi, r_voice.freq_lo};
    assign pw[12*v +: 12]    = {r_voice.pw_hi, r_voice.pw_lo};
    assign control[8*v +: 8] = r_voice.control;
    assign att_dec[8*v +: 8] = r_voice.att_dec;
    assign sus_rel[8*v +: 8] = r_voice.sus_rel;
  end

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_fc_lo    <= '0;
      r_fc_hi    <= '0;
      r_res_filt <= '0;
      r_mode_vol <= '0;
    end else if (w_wr) begin
      case (w_frel)
        32'(FOFS_FC_LO):    r_fc_lo    <= bus.data_in;
        32'(FOFS_FC_HI):    r_fc_hi    <= bus.data_in;
        32'(FOFS_RES_FILT): r_res_filt <= bus.data_in;
        32'(FOFS_MODE_VOL): r_mode_vol <= bus.data_in;
        default: ;
      endcase
    end
  end

  // Read-only sources; everything else reads back the bus latch.
  always_comb begin
    w_rd_hit = 1'b0;
    w_rd_val = '0;
    case (w_frel)
      32'(FOFS_POT_X):   begin w_rd_hit = 1'b1; w_rd_val = pot_x;   end
      32'(FOFS_POT_Y):   begin w_rd_hit = 1'b1; w_rd_val = pot_y;   end
      32'(FOFS_OSC_MON): begin w_rd_hit = 1'b1; w_rd_val = osc_mon; end
      32'(FOFS_ENV_MON): begin w_rd_hit = 1'b1; w_rd_val = env_mon; end
      default: ;
    endcase
  end

  assign w_load      = w_wr | (w_rd & w_rd_hit);
  assign w_load_data = w_wr ? bus.data_in : w_rd_val;

  always_ff @(posedge clk32) begin
    if (reset) begin
      r_data_out <= '0;
      r_ctrl_wr  <= '0;
    end else begin
      r_ctrl_wr <= w_ctrl_hit;
      if (!w_rd) begin
        r_data_out <= '0;
      end else if (w_rd_hit) begin
        r_data_out <= w_rd_val;
      end else begin
        r_data_out <= w_bus_latch;
      end
    end
  end

  // 1 MHz enable: registered compare so the first pulse lands one cycle after div starts.
  always_ff @(posedge clk32) begin
    if (reset) begin
      r_div   <= '0;
      r_ce_1m <= 1'b0;
    end else begin
      r_ce_1m <= (r_div == '0);
      r_div   <= (r_div == DIV_W'(CLK_DIV - 1)) ? '0 : r_div + DIV_W'(1);
    end
  end

  sid_bus_latch #(
    .DECAY_TICKS (DECAY_TICKS)
  ) u_bus_latch (
    .clk32     (clk32),
    .reset     (reset),
    .tick      (r_ce_1m),
    .load      (w_load),
    .load_data (w_load_data),
    .bus_latch (w_bus_latch)
  );

  assign bus.data_out = r_data_out;
  assign ce_1m        = r_ce_1m;
  assign ctrl_wr      = r_ctrl_wr;
  assign fc_lo        = r_fc_lo;
  assign fc_hi        = r_fc_hi;
  assign res_filt     = r_res_filt;
  assign mode_vol     = r_mode_vol;

endmodule

// File: tb/tb_sid_regbank.sv
// Scoreboard bench for sid_regbank: two configurations driven with directed and random bus traffic.
module tb_sid_regbank;
  import sid_pkg::*;

  localparam int unsigned NV_A = 3, CD_A = 32, DT_A = 4, AW_A = 5;
  localparam int unsigned NV_B = 5, CD_B = 3,  DT_B = 0, AW_B = 6;

  typedef struct packed {
    logic        chk;
    logic [7:0]  dout;
    logic        ce;
    logic [7:0]  cw;
    logic [79:0] freq;
    logic [59:0] pw;
    logic [39:0] ctl;
    logic [39:0] ad;
    logic [39:0] sr;
    logic [31:0] filt;
  } exp_t;

  typedef struct packed {
    logic       cs;
    logic       we;
    logic [5:0] a;
    logic [7:0] d;
  } op_t;

  logic clk32 = 1'b0;
  logic reset;
  always #5 clk32 = ~clk32;

  sid_regbank_if #(.ADDR_W(AW_A)) bus_a ();
  sid_regbank_if #(.ADDR_W(AW_B)) bus_b ();

  logic [7:0] pxa, pya, osa, eva, pxb, pyb, osb, evb;

  logic              a_ce;
  logic [NV_A*16-1:0] a_freq;
  logic [NV_A*12-1:0] a_pw;
  logic [NV_A*8-1:0]  a_ctl, a_ad, a_sr;
  logic [NV_A-1:0]    a_cw;
  logic [7:0]         a_fl, a_fh, a_rf, a_mv;

  logic              b_ce;
  logic [NV_B*16-1:0] b_freq;
  logic [NV_B*12-1:0] b_pw;
  logic [NV_B*8-1:0]  b_ctl, b_ad, b_sr;
  logic [NV_B-1:0]    b_cw;
  logic [7:0]         b_fl, b_fh, b_rf, b_mv;

  sid_regbank #(.NVOICES(NV_A), .CLK_DIV(CD_A), .DECAY_TICKS(DT_A), .ADDR_W(AW_A)) dut_a (
    .clk32(clk32), .reset(reset), .bus(bus_a.slave),
    .pot_x(pxa), .pot_y(pya), .osc_mon(osa), .env_mon(eva),
    .ce_1m(a_ce), .freq(a_freq), .pw(a_pw), .control(a_ctl), .att_dec(a_ad), .sus_rel(a_sr),
    .ctrl_wr(a_cw), .fc_lo(a_fl), .fc_hi(a_fh), .res_filt(a_rf), .mode_vol(a_mv)
  );

  sid_regbank #(.NVOICES(NV_B), .CLK_DIV(CD_B), .DECAY_TICKS(DT_B), .ADDR_W(AW_B)) dut_b (
    .clk32(clk32), .reset(reset), .bus(bus_b.slave),
    .pot_x(pxb), .pot_y(pyb), .osc_mon(osb), .env_mon(evb),
    .ce_1m(b_ce), .freq(b_freq), .pw(b_pw), .control(b_ctl), .att_dec(b_ad), .sus_rel(b_sr),
    .ctrl_wr(b_cw), .fc_lo(b_fl), .fc_hi(b_fh), .res_filt(b_rf), .mode_vol(b_mv)
  );

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference model state: a flat byte map of everything written, plus latch and tick bookkeeping.
  logic [7:0]  m_reg   [2][64];
  logic [7:0]  m_latch [2];
  int unsigned m_cnt   [2];
  int unsigned m_cyc   [2];
  logic        m_ce    [2];

  function automatic int unsigned p_nv(input int k);
    return (k == 0) ? NV_A : NV_B;
  endfunction
  function automatic int unsigned p_cd(input int k);
    return (k == 0) ? CD_A : CD_B;
  endfunction
  function automatic int unsigned p_dt(input int k);
    return (k == 0) ? DT_A : DT_B;
  endfunction

  function automatic op_t op_w(input int unsigned a, input logic [7:0] d);
    op_t o;
    o.cs = 1'b1; o.we = 1'b1; o.a = 6'(a); o.d = d;
    return o;
  endfunction
  function automatic op_t op_r(input int unsigned a);
    op_t o;
    o.cs = 1'b1; o.we = 1'b0; o.a = 6'(a); o.d = 8'h00;
    return o;
  endfunction
  function automatic op_t op_idle();
    op_t o;
    o = '0;
    return o;
  endfunction
  function automatic op_t op_rnd(input int unsigned aw);
    op_t o;
    o.cs = ($urandom_range(0, 3) != 0);
    o.we = 1'($urandom_range(0, 1));
    o.a  = 6'($urandom_range(0, (1 << aw) - 1));
    o.d  = 8'($urandom);
    return o;
  endfunction

  // Advance the model by one clock edge and queue the outputs expected after that edge.
  task automatic model(input int k, input logic rst, input op_t o,
                       input logic [7:0] px, input logic [7:0] py,
                       input logic [7:0] os, input logic [7:0] ev);
    exp_t        e;
    int unsigned f, a;
    logic        loaded, ce_now;
    logic [7:0]  src [4];
    e = '0;
    f = 7 * p_nv(k);
    a = 32'(o.a);
    src[0] = px; src[1] = py; src[2] = os; src[3] = ev;
    if (rst) begin
      for (int i = 0; i < 64; i++) m_reg[k][i] = 8'h00;
      m_latch[k] = 8'h00;
      m_cnt[k]   = 0;
      m_cyc[k]   = 0;
      m_ce[k]    = 1'b0;
      e.chk      = 1'b1;
    end else begin
      ce_now   = m_ce[k];
      m_ce[k]  = ((m_cyc[k] % p_cd(k)) == 0);
      m_cyc[k] = m_cyc[k] + 1;
      loaded   = 1'b0;
      e.chk    = 1'b1;
      if (o.cs && o.we) begin
        e.chk = 1'b0;
        if (a < f + 4) m_reg[k][a] = o.d;
        if (a < f && (a % 7) == 4) e.cw[a / 7] = 1'b1;
        m_latch[k] = o.d;
        m_cnt[k]   = p_dt(k);
        loaded     = 1'b1;
      end else if (o.cs) begin
        if (a >= f + 4 && a < f + 8) begin
          e.dout     = src[a - f - 4];
          m_latch[k] = e.dout;
          m_cnt[k]   = p_dt(k);
          loaded     = 1'b1;
        end else begin
          e.dout = m_latch[k];
        end
      end
      if (!loaded && ce_now && m_cnt[k] != 0) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) m_latch[k] = 8'h00;
      end
    end
    e.ce = m_ce[k];
    for (int v = 0; v < int'(p_nv(k)); v++) begin
      e.freq[16*v +: 16] = {m_reg[k][7*v+1], m_reg[k][7*v]};
      e.pw[12*v +: 12]   = {m_reg[k][7*v+3][3:0], m_reg[k][7*v+2]};
      e.ctl[8*v +: 8]    = m_reg[k][7*v+4];
      e.ad[8*v +: 8]     = m_reg[k][7*v+5];
      e.sr[8*v +: 8]     = m_reg[k][7*v+6];
    end
    e.filt = {m_reg[k][f+3], m_reg[k][f+2], m_reg[k][f+1], m_reg[k][f]};
    if (k == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic step(input logic rst, input op_t oa, input op_t ob);
    @(negedge clk32);
    reset         = rst;
    bus_a.cs      = oa.cs;
    bus_a.we      = oa.we;
    bus_a.addr    = oa.a[AW_A-1:0];
    bus_a.data_in = oa.d;
    bus_b.cs      = ob.cs;
    bus_b.we      = ob.we;
    bus_b.addr    = ob.a[AW_B-1:0];
    bus_b.data_in = ob.d;
    pxa = 8'($urandom); pya = 8'($urandom); osa = 8'($urandom); eva = 8'($urandom);
    pxb = 8'($urandom); pyb = 8'($urandom); osb = 8'($urandom); evb = 8'($urandom);
    model(0, rst, oa, pxa, pya, osa, eva);
    model(1, rst, ob, pxb, pyb, osb, evb);
  endtask

  task automatic cmp(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string p, input exp_t e, input logic [7:0] dout,
                            input logic ce, input logic [7:0] cw, input logic [79:0] fr,
                            input logic [59:0] pwv, input logic [39:0] ctl,
                            input logic [39:0] ad, input logic [39:0] sr, input logic [31:0] filt);
    if (e.chk) cmp({p, "_data_out"}, 80'(dout), 80'(e.dout));
    cmp({p, "_ce_1m"},   80'(ce),   80'(e.ce));
    cmp({p, "_ctrl_wr"}, 80'(cw),   80'(e.cw));
    cmp({p, "_freq"},    fr,        e.freq);
    cmp({p, "_pw"},      80'(pwv),  80'(e.pw));
    cmp({p, "_control"}, 80'(ctl),  80'(e.ctl));
    cmp({p, "_att_dec"}, 80'(ad),   80'(e.ad));
    cmp({p, "_sus_rel"}, 80'(sr),   80'(e.sr));
    cmp({p, "_filter"},  80'(filt), 80'(e.filt));
  endtask

  exp_t ea, eb;

  // Monitor: one expected entry per edge, compared just after the edge.
  always @(posedge clk32) begin
    #1;
    if (q_a.size() != 0) begin
      ea = q_a.pop_front();
      check_inst("A", ea, bus_a.data_out, a_ce, 8'(a_cw), 80'(a_freq), 60'(a_pw),
                 40'(a_ctl), 40'(a_ad), 40'(a_sr), {a_mv, a_rf, a_fh, a_fl});
    end
    if (q_b.size() != 0) begin
      eb = q_b.pop_front();
      check_inst("B", eb, bus_b.data_out, b_ce, 8'(b_cw), b_freq, b_pw,
                 b_ctl, b_ad, b_sr, {b_mv, b_rf, b_fh, b_fl});
    end
  end

  initial begin
    reset = 1'b1;
    bus_a.cs = 1'b0; bus_a.we = 1'b0; bus_a.addr = '0; bus_a.data_in = '0;
    bus_b.cs = 1'b0; bus_b.we = 1'b0; bus_b.addr = '0; bus_b.data_in = '0;
    pxa = '0; pya = '0; osa = '0; eva = '0;
    pxb = '0; pyb = '0; osb = '0; evb = '0;

    // Writes during reset must be ignored.
    repeat (4) step(1'b1, op_w(4, 8'hFF), op_w(38, 8'hFF));
    repeat (70) step(1'b0, op_idle(), op_idle());

    step(1'b0, op_w(4, 8'h41),  op_w(38, 8'h0F));
    step(1'b0, op_w(11, 8'h11), op_r(39));
    step(1'b0, op_idle(),       op_w(60, 8'h77));
    step(1'b0, op_w(3, 8'hFF),  op_r(60));
    step(1'b0, op_r(3),         op_w(32, 8'h20));
    step(1'b0, op_r(27),        op_w(32, 8'h21));
    step(1'b0, op_r(5),         op_w(4, 8'h08));
    step(1'b0, op_r(31),        op_r(50));
    step(1'b0, op_w(0, 8'hA5),  op_r(42));
    repeat (200) step(1'b0, op_r(0), op_rnd(AW_B));

    repeat (2) step(1'b1, op_w(7, 8'h12), op_w(7, 8'h12));
    repeat (500) step(1'b0, op_rnd(AW_A), op_rnd(AW_B));
    step(1'b0, op_idle(), op_idle());

    repeat (2) @(negedge clk32);
    cmp("A_queue_drained", 80'(q_a.size()), 80'(0));
    cmp("B_queue_drained", 80'(q_b.size()), 80'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
